// File: rtl/arm_pkg.sv
// Shared types and constants for the ARM fetch stage: state encoding, IF/ID payload, defaults.
package arm_pkg;

  localparam int unsigned INSTR_W = 32;
  localparam int unsigned ADDR_W  = 32;

  localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0000_0000;
  localparam logic [ADDR_W-1:0]  RESET_PC  = 32'h0000_0000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    HOLD = 2'd2,
    KILL = 2'd3
  } fetch_state_t;

  // Word travelling into IF/ID: fetch address + 4 and the instruction itself
  typedef struct packed {
    logic [ADDR_W-1:0]  pc;
    logic [INSTR_W-1:0] instr;
  } id_payload_t;

  function automatic logic [ADDR_W-1:0] pc_next(input logic [ADDR_W-1:0] pc);
    return pc + ADDR_W'(4);
  endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// Instruction-memory request/response bus; fetch stage is master, memory is slave.
interface fetch_stage_if;
  import arm_pkg::*;

  logic               imem_req;
  logic [ADDR_W-1:0]  imem_addr;
  logic               imem_rvalid;
  logic [INSTR_W-1:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_rvalid,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_rvalid,
    output imem_rdata
  );

endinterface

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: flush dominates freeze; a free cycle without load inserts a bubble.
module if_id_reg
  import arm_pkg::*;
#(
  parameter logic [INSTR_W-1:0] NOP = NOP_INSTR
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush,
  input  logic               freeze,
  input  logic               load,
  input  id_payload_t        load_data,
  output logic [ADDR_W-1:0]  pc_id,
  output logic [INSTR_W-1:0] instr_id,
  output logic               valid_id
);

  logic [ADDR_W-1:0]  pc_q,    pc_d;
  logic [INSTR_W-1:0] instr_q, instr_d;
  logic               valid_q, valid_d;

  always_comb begin
    pc_d    = pc_q;
    instr_d = instr_q;
    valid_d = valid_q;
    if (flush) begin
      valid_d = 1'b0;
      instr_d = NOP;
    end else if (!freeze) begin
      if (load) begin
        pc_d    = load_data.pc;
        instr_d = load_data.instr;
        valid_d = 1'b1;
      end else begin
        valid_d = 1'b0;
        instr_d = NOP;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_q    <= '0;
      instr_q <= NOP;
      valid_q <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      instr_q <= instr_d;
      valid_q <= valid_d;
    end
  end

  assign pc_id    = pc_q;
  assign instr_id = instr_q;
  assign valid_id = valid_q;

endmodule

// File: rtl/fetch_stage.sv
// ARM IF stage with IF/ID register, single-outstanding imem requests, hazard freeze and branch redirect.
// Define FETCH_PERF_EN to add saturating fetch/stall/kill counters.
module fetch_stage #(
  parameter logic [31:0] RESET_PC  = arm_pkg::RESET_PC,
  parameter logic [31:0] NOP_INSTR = arm_pkg::NOP_INSTR
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       hazard,
  input  logic                       branch_taken_EXE,
  input  logic [arm_pkg::ADDR_W-1:0] branch_addr_EXE,
  fetch_stage_if.master              imem,
  output logic [arm_pkg::ADDR_W-1:0] PC_ID,
  output logic [arm_pkg::INSTR_W-1:0] instr_ID,
  output logic                       valid_ID
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]                fetch_cnt,
  output logic [31:0]                stall_cnt,
  output logic [31:0]                kill_cnt
`endif
);
  import arm_pkg::*;

  fetch_state_t      state_q, state_d;
  logic [ADDR_W-1:0] pc_q,    pc_d;
  logic              req_q,   req_d;
  logic [ADDR_W-1:0] addr_q,  addr_d;
  id_payload_t       hold_q,  hold_d;

  logic              load;
  id_payload_t       load_data;
  logic [ADDR_W-1:0] pc_inc;

  assign pc_inc = pc_next(pc_q);

  // Next-state: the hold buffer is full exactly when the FSM sits in HOLD
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    req_d     = req_q;
    addr_d    = addr_q;
    hold_d    = hold_q;
    load      = 1'b0;
    load_data = hold_q;

    unique case (state_q)
      IDLE: begin
        state_d = WAIT;
        req_d   = 1'b1;
        addr_d  = pc_q;
      end
      WAIT: begin
        if (imem.imem_rvalid) begin
          pc_d = pc_inc;
          if (hazard) begin
            hold_d  = '{pc: pc_inc, instr: imem.imem_rdata};
            req_d   = 1'b0;
            state_d = HOLD;
          end else begin
            load      = 1'b1;
            load_data = '{pc: pc_inc, instr: imem.imem_rdata};
            req_d     = 1'b1;
            addr_d    = pc_inc;
          end
        end
      end
      HOLD: begin
        if (!hazard) begin
          load    = 1'b1;
          req_d   = 1'b1;
          addr_d  = pc_q;
          state_d = WAIT;
        end
      end
      KILL: begin
        if (imem.imem_rvalid) begin
          req_d   = 1'b1;
          addr_d  = pc_q;
          state_d = WAIT;
        end
      end
      default: begin
        state_d = IDLE;
        req_d   = 1'b0;
      end
    endcase

    // Redirect overrides everything above, including a pending freeze
    if (branch_taken_EXE) begin
      load = 1'b0;
      pc_d = branch_addr_EXE;
      if ((state_q == WAIT || state_q == KILL) && !imem.imem_rvalid) begin
        req_d   = 1'b0;
        addr_d  = addr_q;
        state_d = KILL;
      end else begin
        req_d   = 1'b1;
        addr_d  = branch_addr_EXE;
        state_d = WAIT;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      pc_q    <= RESET_PC;
      req_q   <= 1'b0;
      addr_q  <= RESET_PC;
      hold_q  <= '{pc: '0, instr: NOP_INSTR};
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      req_q   <= req_d;
      addr_q  <= addr_d;
      hold_q  <= hold_d;
    end
  end

  assign imem.imem_req  = req_q;
  assign imem.imem_addr = addr_q;

  if_id_reg #(
    .NOP (NOP_INSTR)
  ) u_if_id (
    .clk       (clk),
    .rst       (rst),
    .flush     (branch_taken_EXE),
    .freeze    (hazard),
    .load      (load),
    .load_data (load_data),
    .pc_id     (PC_ID),
    .instr_id  (instr_ID),
    .valid_id  (valid_ID)
  );

`ifdef FETCH_PERF_EN
  logic        discard;
  logic [31:0] fetch_cnt_q, fetch_cnt_d;
  logic [31:0] stall_cnt_q, stall_cnt_d;
  logic [31:0] kill_cnt_q,  kill_cnt_d;

  assign discard = imem.imem_rvalid &&
                   (state_q == KILL || (state_q == WAIT && branch_taken_EXE));

  always_comb begin
    fetch_cnt_d = fetch_cnt_q;
    stall_cnt_d = stall_cnt_q;
    kill_cnt_d  = kill_cnt_q;
    if (load && fetch_cnt_q != '1)                 fetch_cnt_d = fetch_cnt_q + 32'd1;
    if (hazard && valid_ID && stall_cnt_q != '1)   stall_cnt_d = stall_cnt_q + 32'd1;
    if (discard && kill_cnt_q != '1)               kill_cnt_d  = kill_cnt_q + 32'd1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetch_cnt_q <= '0;
      stall_cnt_q <= '0;
      kill_cnt_q  <= '0;
    end else begin
      fetch_cnt_q <= fetch_cnt_d;
      stall_cnt_q <= stall_cnt_d;
      kill_cnt_q  <= kill_cnt_d;
    end
  end

  assign fetch_cnt = fetch_cnt_q;
  assign stall_cnt = stall_cnt_q;
  assign kill_cnt  = kill_cnt_q;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: program-order stream model, variable-latency memory, random hazards/branches.
module tb_fetch_stage;

  logic        clk;
  logic        rst;
  logic        hazard;
  logic        branch_taken_EXE;
  logic [31:0] branch_addr_EXE;
  logic [31:0] PC_ID;
  logic [31:0] instr_ID;
  logic        valid_ID;
`ifdef FETCH_PERF_EN
  logic [31:0] fetch_cnt, stall_cnt, kill_cnt;
`endif

  fetch_stage_if imem_bus ();

  fetch_stage dut (
    .clk              (clk),
    .rst              (rst),
    .hazard           (hazard),
    .branch_taken_EXE (branch_taken_EXE),
    .branch_addr_EXE  (branch_addr_EXE),
    .imem             (imem_bus),
    .PC_ID            (PC_ID),
    .instr_ID         (instr_ID),
    .valid_ID         (valid_ID)
`ifdef FETCH_PERF_EN
    ,
    .fetch_cnt        (fetch_cnt),
    .stall_cnt        (stall_cnt),
    .kill_cnt         (kill_cnt)
`endif
  );

  localparam logic [31:0] T_RESET_PC = 32'h0000_0000;
  localparam logic [31:0] T_NOP      = 32'h0000_0000;

  typedef struct {
    logic [31:0] pc_id;
    logic [31:0] instr;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] exp_pc;
  int          n_tests = 0;
  int          n_fail  = 0;
  int          n_instr = 0;
  int          n_since_reset = 0;
  int          mem_lat = 1;   // 0 selects a random latency 1..4 per request

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Expected ID stream: sequential words from the current fetch pointer
  task automatic refill();
    exp_t e;
    while (exp_q.size() < 8) begin
      e.pc_id = exp_pc + 32'd4;
      e.instr = mem_word(exp_pc);
      exp_q.push_back(e);
      exp_pc  = exp_pc + 32'd4;
    end
  endtask

  task automatic tick(input logic h, input logic b, input logic [31:0] ba);
    @(negedge clk);
    hazard           = h;
    branch_taken_EXE = b;
    branch_addr_EXE  = ba;
    if (b) begin
      exp_q.delete();
      exp_pc = ba;
    end
    refill();
  endtask

  task automatic do_reset(input string tag);
    @(negedge clk);
    rst              = 1'b0;
    hazard           = 1'b0;
    branch_taken_EXE = 1'b0;
    branch_addr_EXE  = 32'h0;
    exp_q.delete();
    exp_pc        = T_RESET_PC;
    n_since_reset = 0;
    #1;
    check({tag, "_req"},   32'(imem_bus.imem_req), 32'h0);
    check({tag, "_addr"},  imem_bus.imem_addr,     T_RESET_PC);
    check({tag, "_pcid"},  PC_ID,                  32'h0);
    check({tag, "_instr"}, instr_ID,               T_NOP);
    check({tag, "_valid"}, 32'(valid_ID),          32'h0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    refill();
  endtask

  // Memory: one outstanding request, response pulsed after mem_lat cycles
  initial begin : memory
    logic        busy;
    int          cnt;
    logic [31:0] maddr;
    busy = 1'b0; cnt = 0; maddr = 32'h0;
    imem_bus.imem_rvalid = 1'b0;
    imem_bus.imem_rdata  = 32'h0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        busy = 1'b0;
        imem_bus.imem_rvalid = 1'b0;
      end else begin
        if (imem_bus.imem_rvalid) begin
          imem_bus.imem_rvalid = 1'b0;
          busy = 1'b0;
        end
        if (busy) begin
          check("addr_stable", imem_bus.imem_addr, maddr);
          cnt--;
        end else if (imem_bus.imem_req) begin
          busy  = 1'b1;
          maddr = imem_bus.imem_addr;
          cnt   = ((mem_lat == 0) ? $urandom_range(1, 4) : mem_lat) - 1;
        end
        if (busy && cnt == 0) begin
          imem_bus.imem_rvalid = 1'b1;
          imem_bus.imem_rdata  = mem_word(maddr);
        end
      end
    end
  end

  // Monitor: classify each edge by the inputs seen there and compare IF/ID afterwards
  initial begin : monitor
    logic        h, b, r;
    logic [31:0] p_pc, p_instr;
    logic        p_valid;
    exp_t        e;
    p_pc = 32'h0; p_instr = T_NOP; p_valid = 1'b0;
    forever begin
      @(posedge clk);
      h = hazard; b = branch_taken_EXE; r = rst;
      #1;
      if (r) begin
        if (b) begin
          check("flush_valid", 32'(valid_ID), 32'h0);
          check("flush_instr", instr_ID, T_NOP);
        end else if (h) begin
          check("freeze_pc",    PC_ID,         p_pc);
          check("freeze_instr", instr_ID,      p_instr);
          check("freeze_valid", 32'(valid_ID), 32'(p_valid));
        end else if (valid_ID) begin
          n_instr++;
          n_since_reset++;
          if (exp_q.size() == 0) begin
            check("instr_unexpected", PC_ID, 32'hDEAD_BEEF);
          end else begin
            e = exp_q.pop_front();
            check("instr_pcid", PC_ID,    e.pc_id);
            check("instr_word", instr_ID, e.instr);
          end
        end else begin
          check("bubble_nop", instr_ID, T_NOP);
        end
      end
      p_pc = PC_ID; p_instr = instr_ID; p_valid = valid_ID;
    end
  end

  initial begin : stimulus
    int          base;
    logic        found;
    logic        h, b;
    logic [31:0] ba;
    rst = 1'b0; hazard = 1'b0; branch_taken_EXE = 1'b0; branch_addr_EXE = 32'h0;
    exp_pc = T_RESET_PC;

    // Latency 1, no hazards: one instruction per cycle after the first two edges
    mem_lat = 1;
    do_reset("reset");
    base = n_instr;
    repeat (20) tick(1'b0, 1'b0, 32'h0);
    check("lat1_rate", 32'(n_instr - base), 32'd19);

    // Latency 3: roughly one instruction every third cycle
    mem_lat = 3;
    base = n_instr;
    repeat (18) tick(1'b0, 1'b0, 32'h0);
    check("lat3_rate", 32'((n_instr - base >= 5) && (n_instr - base <= 7)), 32'h1);

    // Hazard held across a response, then released
    repeat (2) tick(1'b0, 1'b0, 32'h0);
    repeat (4) tick(1'b1, 1'b0, 32'h0);
    repeat (6) tick(1'b0, 1'b0, 32'h0);

    // Redirect while a latency-3 request is outstanding
    found = 1'b0;
    for (int i = 0; i < 12 && !found; i++) begin
      tick(1'b0, 1'b0, 32'h0);
      #2;
      found = imem_bus.imem_req && !imem_bus.imem_rvalid;
    end
    check("branch_setup", 32'(found), 32'h1);
    tick(1'b0, 1'b1, 32'h0000_0100);
    repeat (10) tick(1'b0, 1'b0, 32'h0);

    // Redirect and hazard together: flush wins
    tick(1'b1, 1'b1, 32'h0000_0200);
    repeat (3) tick(1'b1, 1'b0, 32'h0);
    repeat (8) tick(1'b0, 1'b0, 32'h0);

    // Address wrap-around through the top of the address space
    mem_lat = 1;
    tick(1'b0, 1'b1, 32'hFFFF_FFF8);
    repeat (8) tick(1'b0, 1'b0, 32'h0);

    // Reset in the middle of an outstanding request
    mem_lat = 3;
    repeat (2) tick(1'b0, 1'b0, 32'h0);
    do_reset("midreset");

    // Random hazards, redirects and latencies
    mem_lat = 0;
    for (int i = 0; i < 3000; i++) begin
      h  = ($urandom_range(0, 3) == 0);
      b  = ($urandom_range(0, 15) == 0);
      ba = $urandom & 32'hFFFF_FFFC;
      tick(h, b, ba);
    end
    tick(1'b0, 1'b0, 32'h0);
    check("progress", 32'(n_instr > 300), 32'h1);
`ifdef FETCH_PERF_EN
    check("fetch_cnt", fetch_cnt, 32'(n_since_reset));
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- IF stage plus IF/ID pipeline register of the 32-bit ARM pipeline.
- Drives PC_ID/instr_ID/valid_ID into ID, where the hazard unit compares src1_ID/src2_ID against EXE/MEM destinations.
- Consumes that unit's `hazard` output as a freeze request, and branch_taken/branch_addr from EXE as a redirect.
- Talks to a variable-latency instruction memory with at most one outstanding request.

Parameters:
RESET_PC, 32'h0000_0000, first fetch address after reset
NOP_INSTR, 32'h0000_0000, instruction word presented on instr_ID when valid_ID=0

Ports:
clk  in  1  single clock, rising edge
rst  in  1  asynchronous active-low reset
hazard  in  1  freeze request from hazard detection; stall PC and IF/ID
branch_taken_EXE  in  1  redirect/flush request from EXE
branch_addr_EXE  in  32  redirect target, word aligned
imem_req  out  1  request valid to instruction memory
imem_addr  out  32  request address, held stable while request outstanding
imem_rvalid  in  1  response valid, one-cycle pulse
imem_rdata  in  32  response instruction word
PC_ID  out  32  fetch address + 4 of the instruction in IF/ID
instr_ID  out  32  instruction in IF/ID
valid_ID  out  1  IF/ID holds a live instruction

Behaviour:
- Reset (rst=0, async): PC=RESET_PC; state=IDLE; imem_req=0; imem_addr=RESET_PC; PC_ID=0; instr_ID=NOP_INSTR; valid_ID=0; hold buffer empty.
- States:
  - IDLE: one cycle after reset release, then issue the request for PC and go to WAIT.
  - WAIT: imem_req=1, imem_addr=PC. The request stays asserted until imem_rvalid.
    - rvalid, IF/ID free: load IF/ID, PC+=4, issue the next request in the same cycle (back-to-back), stay in WAIT.
    - rvalid while hazard=1: store the word in the hold buffer, PC+=4, imem_req=0, go to HOLD.
  - HOLD: IF/ID frozen, hold buffer full.
    - When hazard drops: move the hold buffer into IF/ID at that edge, issue a request for PC, go to WAIT.
  - KILL: a request is outstanding whose response must be discarded. imem_req=0.
    - On rvalid: drop the data, issue a request for PC (the redirect target), go to WAIT.
- IF/ID is "free" when hazard=0; it updates only when free.
- When IF/ID is free and no data arrives, valid_ID<=0 (bubble).
- Freeze: hazard=1 holds PC_ID/instr_ID/valid_ID unchanged. No new request is issued while hazard=1 and the hold buffer is full.
- Branch priority: branch_taken_EXE overrides hazard. On that edge:
  - valid_ID<=0, instr_ID<=NOP_INSTR.
  - Hold buffer cleared.
  - PC<=branch_addr_EXE.
  - From WAIT without rvalid: go to KILL.
  - From WAIT with rvalid in the same cycle: discard the data and issue a request to branch_addr_EXE, stay in WAIT.
  - From HOLD/IDLE: request branch_addr_EXE next cycle via WAIT.
- Branch while in KILL: update PC only; stay in KILL.
- PC arithmetic: 32-bit modulo. 32'hFFFF_FFFC+4 wraps to 0.
- Minimum memory latency is 1 cycle. rvalid with no outstanding request is ignored.
- Reset mid-request: all state cleared. The memory is assumed reset by the same rst.

Optional Feature:
- FETCH_PERF_EN defined: adds 32-bit saturating output counters.
  - fetch_cnt: responses accepted into IF/ID.
  - stall_cnt: cycles with hazard=1 and valid_ID=1.
  - kill_cnt: responses discarded.
  - All reset to 0.
- FETCH_PERF_EN not defined: these ports and their logic are absent; all other behaviour is identical.

Decomposition:
- Shared package arm_pkg holds:
  - fetch_state_t enum {IDLE, WAIT, HOLD, KILL};
  - NOP_INSTR and RESET_PC default constants;
  - INSTR_W=32.
- Natural sub-module if_id_reg: holds PC_ID/instr_ID/valid_ID with freeze and flush inputs, flush dominant.

Test Plan:
- Reset then memory latency 1, hazard=0: requests at 0,4,8,…; valid_ID=1 from cycle 3; PC_ID sequence 4,8,12; one instruction per cycle.
- Latency 3, hazard=0: a bubble (valid_ID=0) for 2 of every 3 cycles; imem_addr stable across each wait.
- hazard=1 for 4 cycles while a response for addr 8 arrives: IF/ID frozen on addr 4's word; data for 8 held. When hazard drops, PC_ID=12 next cycle, and a request for 12 issues that cycle.
- branch_taken_EXE=1, branch_addr_EXE=32'h100, during an outstanding request at 0x10 (latency 3):
  - valid_ID=0 next cycle;
  - the 0x10 response is discarded, kill_cnt=1;
  - next request is 0x100, PC_ID=0x104.
- branch_taken_EXE and hazard both 1 in the same cycle: flush wins, valid_ID=0, then redirect to target.
- Wrap-around: RESET_PC=32'hFFFF_FFF8: fetches FFFF_FFF8, FFFF_FFFC, 0000_0000; PC_ID for last = 32'h4.
